// File: rtl/fir_mac_sequencer.sv
// Sequential FIR filter that time-shares one external 12x12 multiplier across NTAPS taps.
// Define FIR_OUT_SAT_EN to saturate Dout to the signed 24-bit range. Without it, Dout wraps.
module fir_mac_sequencer #(
    parameter int NTAPS = 8,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic signed [11:0]  Din,
    input  logic                Din_Valid,
    output logic                Din_Ready,
    input  logic                Coeff_We,
    input  logic [AW-1:0]       Coeff_Addr,
    input  logic signed [11:0]  Coeff_Wdata,
    output logic                Busy,
    output logic signed [11:0]  Mult_Din,
    output logic signed [11:0]  Mult_Coeff,
    input  logic signed [23:0]  Mult_Product,
    output logic signed [23:0]  Dout,
    output logic                Dout_Valid,
    input  logic                Dout_Ready
);

    localparam int ACCW = 24 + AW;
    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [AW-1:0]          tap_k;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [11:0]     x_line [NTAPS];
    logic signed [11:0]     coeff  [NTAPS];
    logic                   din_hs;
    logic                   last_tap;
    logic signed [23:0]     dout_load;

    assign din_hs   = (state == IDLE) && Din_Valid;
    assign last_tap = (tap_k == LAST_TAP);
    assign acc_sum  = acc + ACCW'(Mult_Product);

`ifdef FIR_OUT_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(8388607);
    localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-8388608);

    always_comb begin
        dout_load = acc_sum[23:0];
        if (acc_sum > SAT_HI)
            dout_load = 24'sh7FFFFF;
        else if (acc_sum < SAT_LO)
            dout_load = -24'sh800000;
    end
`else
    always_comb begin
        dout_load = acc_sum[23:0];
    end
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Multiplier operands are only live during MAC so the shared multiplier sees zeros otherwise
    always_comb begin
        state_next = state;
        Din_Ready  = 1'b0;
        Busy       = 1'b0;
        Mult_Din   = '0;
        Mult_Coeff = '0;
        case (state)
            IDLE: begin
                Din_Ready = 1'b1;
                if (Din_Valid)
                    state_next = MAC;
            end
            MAC: begin
                Busy       = 1'b1;
                Mult_Din   = x_line[tap_k];
                Mult_Coeff = coeff[tap_k];
                if (last_tap)
                    state_next = OUT;
            end
            OUT: begin
                Busy = 1'b1;
                if (Dout_Ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tap_k      <= '0;
            acc        <= '0;
            Dout       <= '0;
            Dout_Valid <= 1'b0;
            for (int i = 0; i < NTAPS; i++)
                x_line[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_hs) begin
                        x_line[0] <= Din;
                        for (int i = 1; i < NTAPS; i++)
                            x_line[i] <= x_line[i-1];
                        acc   <= '0;
                        tap_k <= '0;
                    end
                end
                MAC: begin
                    acc   <= acc_sum;
                    tap_k <= tap_k + AW'(1);
                    if (last_tap) begin
                        Dout       <= dout_load;
                        Dout_Valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (Dout_Ready)
                        Dout_Valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Writes are accepted only in IDLE, so the bank never changes under a running pass
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                coeff[i] <= '0;
        end else if ((state == IDLE) && Coeff_We) begin
            coeff[Coeff_Addr] <= Coeff_Wdata;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed self-checking bench for fir_mac_sequencer (NTAPS = 8) with a behavioural multiplier.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 8;
    localparam int AW    = 3;

    logic               Clk;
    logic               Rst_n;
    logic signed [11:0] Din;
    logic               Din_Valid;
    logic               Din_Ready;
    logic               Coeff_We;
    logic [AW-1:0]      Coeff_Addr;
    logic signed [11:0] Coeff_Wdata;
    logic               Busy;
    logic signed [11:0] Mult_Din;
    logic signed [11:0] Mult_Coeff;
    logic signed [23:0] Mult_Product;
    logic signed [23:0] Dout;
    logic               Dout_Valid;
    logic               Dout_Ready;

    int passed = 0;
    int total  = 0;

    fir_mac_sequencer #(.NTAPS(NTAPS), .AW(AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Din(Din), .Din_Valid(Din_Valid), .Din_Ready(Din_Ready),
        .Coeff_We(Coeff_We), .Coeff_Addr(Coeff_Addr), .Coeff_Wdata(Coeff_Wdata),
        .Busy(Busy), .Mult_Din(Mult_Din), .Mult_Coeff(Mult_Coeff), .Mult_Product(Mult_Product),
        .Dout(Dout), .Dout_Valid(Dout_Valid), .Dout_Ready(Dout_Ready)
    );

    assign Mult_Product = Mult_Din * Mult_Coeff;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        Din = '0; Din_Valid = 0; Coeff_We = 0; Coeff_Addr = '0; Coeff_Wdata = '0; Dout_Ready = 1;
        Rst_n = 0;
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1;
        @(negedge Clk);
    endtask

    task automatic write_coeff(input int addr, input int val);
        @(negedge Clk);
        Coeff_We = 1; Coeff_Addr = AW'(addr); Coeff_Wdata = 12'(val);
        @(negedge Clk);
        Coeff_We = 0;
    endtask

    task automatic send_sample(input int val);
        int n;
        n = 0;
        @(negedge Clk);
        while (Din_Ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        Din = 12'(val); Din_Valid = 1;
        @(posedge Clk);
        #1 Din_Valid = 0;
    endtask

    // Called #1 after the handshake edge; lat counts edges until Dout_Valid (40 means timeout)
    task automatic wait_result(output logic signed [23:0] d, output int lat);
        lat = 0;
        while (Dout_Valid !== 1'b1 && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        d = Dout;
    endtask

    task automatic test_reset();
        Din = '0; Din_Valid = 0; Coeff_We = 0; Coeff_Addr = '0; Coeff_Wdata = '0; Dout_Ready = 1;
        Rst_n = 0;
        #12;
        total++; if (Din_Ready !== 1'b1)   $display("[TB] FAIL reset_din_ready: got %b want 1", Din_Ready); else passed++;
        total++; if (Busy !== 1'b0)        $display("[TB] FAIL reset_busy: got %b want 0", Busy); else passed++;
        total++; if (Dout_Valid !== 1'b0)  $display("[TB] FAIL reset_dout_valid: got %b want 0", Dout_Valid); else passed++;
        total++; if (Dout !== 24'sd0)      $display("[TB] FAIL reset_dout: got %0d want 0", Dout); else passed++;
        total++; if (Mult_Din !== 12'sd0)  $display("[TB] FAIL reset_mult_din: got %0d want 0", Mult_Din); else passed++;
        total++; if (Mult_Coeff !== 12'sd0) $display("[TB] FAIL reset_mult_coeff: got %0d want 0", Mult_Coeff); else passed++;
        @(negedge Clk);
        Rst_n = 1;
        @(negedge Clk);
    endtask

    task automatic test_single_tap();
        logic signed [23:0] d;
        int lat;
        do_reset();
        write_coeff(0, 1);
        send_sample(100);
        wait_result(d, lat);
        total++; if (lat !== 8)        $display("[TB] FAIL single_tap_latency: got %0d edges want 8", lat); else passed++;
        total++; if (d !== 24'sd100)   $display("[TB] FAIL single_tap_dout: got %0d want 100", d); else passed++;
    endtask

    task automatic test_impulse();
        logic signed [23:0] d;
        int lat;
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coeff(k, k + 1);
        for (int j = 0; j < NTAPS; j++) begin
            send_sample(j == 0 ? 100 : 0);
            wait_result(d, lat);
            total++;
            if (lat >= 40 || d !== 24'((j + 1) * 100))
                $display("[TB] FAIL impulse_out%0d: got %0d (lat %0d) want %0d", j, d, lat, (j + 1) * 100);
            else passed++;
        end
    endtask

    task automatic test_neg_corner();
        logic signed [23:0] d;
        int lat;
        do_reset();
        write_coeff(0, -2048);
        send_sample(-2048);
        wait_result(d, lat);
        total++; if (lat >= 40 || d !== 24'sh400000) $display("[TB] FAIL neg_corner_dout: got %0d want 4194304", d); else passed++;
    endtask

    task automatic test_saturation();
        logic signed [23:0] d;
        logic signed [23:0] first;
        logic signed [23:0] exp9;
        int lat;
`ifdef FIR_OUT_SAT_EN
        exp9 = 24'sh7FFFFF;
`else
        exp9 = 24'shFF8008;
`endif
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coeff(k, 2047);
        first = '0;
        for (int j = 0; j < 9; j++) begin
            send_sample(2047);
            wait_result(d, lat);
            if (j == 0) first = d;
        end
        total++; if (first !== 24'sd4190209) $display("[TB] FAIL sat_first_out: got %0d want 4190209", first); else passed++;
        total++; if (lat >= 40 || d !== exp9) $display("[TB] FAIL sat_ninth_out: got %h want %h", d, exp9); else passed++;
    endtask

    task automatic test_backpressure();
        logic signed [23:0] d;
        int lat;
        do_reset();
        write_coeff(0, 1);
        Dout_Ready = 0;
        send_sample(55);
        wait_result(d, lat);
        total++; if (lat >= 40 || d !== 24'sd55) $display("[TB] FAIL bp_first_dout: got %0d want 55", d); else passed++;
        for (int n = 0; n < 5; n++) begin
            @(negedge Clk);
            Coeff_We = 1; Coeff_Addr = 3'd0; Coeff_Wdata = 12'sd7;
            total++;
            if (Dout !== 24'sd55 || Dout_Valid !== 1'b1 || Din_Ready !== 1'b0 || Busy !== 1'b1)
                $display("[TB] FAIL bp_hold_cycle%0d: got dout=%0d v=%b rdy=%b busy=%b want 55/1/0/1",
                         n, Dout, Dout_Valid, Din_Ready, Busy);
            else passed++;
        end
        @(negedge Clk);
        Coeff_We = 0; Dout_Ready = 1;
        @(posedge Clk);
        #1;
        total++; if (Dout_Valid !== 1'b0) $display("[TB] FAIL bp_idle_valid: got %b want 0", Dout_Valid); else passed++;
        total++; if (Dout !== 24'sd55)    $display("[TB] FAIL bp_idle_dout_hold: got %0d want 55", Dout); else passed++;
        total++; if (Din_Ready !== 1'b1)  $display("[TB] FAIL bp_idle_ready: got %b want 1", Din_Ready); else passed++;
        send_sample(10);
        wait_result(d, lat);
        total++; if (lat >= 40 || d !== 24'sd10) $display("[TB] FAIL bp_dropped_write_readback: got %0d want 10", d); else passed++;
    endtask

    task automatic test_simul_write();
        logic signed [23:0] d;
        int lat;
        do_reset();
        write_coeff(0, 1);
        @(negedge Clk);
        Coeff_We = 1; Coeff_Addr = 3'd0; Coeff_Wdata = 12'sd3;
        Din = 12'sd20; Din_Valid = 1;
        @(posedge Clk);
        #1 Coeff_We = 0; Din_Valid = 0;
        wait_result(d, lat);
        total++; if (lat >= 40 || d !== 24'sd60) $display("[TB] FAIL simul_write_dout: got %0d want 60", d); else passed++;
    endtask

    task automatic test_back_to_back();
        int hs [3];
        logic signed [23:0] outs [3];
        int vals [3];
        int cnt;
        int ocnt;
        vals[0] = 11; vals[1] = -22; vals[2] = 33;
        do_reset();
        write_coeff(0, 1);
        cnt = 0; ocnt = 0;
        Dout_Ready = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (Dout_Valid === 1'b1 && ocnt < 3) begin
                outs[ocnt] = Dout;
                ocnt++;
            end
            if (Din_Ready === 1'b1 && cnt < 3) begin
                Din = 12'(vals[cnt]); Din_Valid = 1;
                hs[cnt] = n;
                cnt++;
            end else begin
                Din_Valid = 0;
            end
        end
        total++; if (cnt !== 3 || ocnt !== 3) $display("[TB] FAIL b2b_counts: got %0d in %0d out want 3 3", cnt, ocnt); else passed++;
        total++; if (hs[1] - hs[0] !== 10) $display("[TB] FAIL b2b_period_0: got %0d want 10", hs[1] - hs[0]); else passed++;
        total++; if (hs[2] - hs[1] !== 10) $display("[TB] FAIL b2b_period_1: got %0d want 10", hs[2] - hs[1]); else passed++;
        for (int j = 0; j < 3; j++) begin
            total++;
            if (outs[j] !== 24'(vals[j])) $display("[TB] FAIL b2b_out%0d: got %0d want %0d", j, outs[j], vals[j]);
            else passed++;
        end
    endtask

    task automatic test_reset_abort();
        logic signed [23:0] d;
        int lat;
        int seen;
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coeff(k, k + 1);
        send_sample(100);
        repeat (3) @(posedge Clk);
        #1;
        total++; if (Mult_Coeff !== 12'sd4) $display("[TB] FAIL abort_at_k3: got coeff %0d want 4", Mult_Coeff); else passed++;
        #1 Rst_n = 0;
        #1;
        total++;
        if (Busy !== 1'b0 || Din_Ready !== 1'b1 || Mult_Din !== 12'sd0 || Mult_Coeff !== 12'sd0 ||
            Dout !== 24'sd0 || Dout_Valid !== 1'b0)
            $display("[TB] FAIL abort_outputs: got busy=%b rdy=%b md=%0d mc=%0d dout=%0d v=%b want 0/1/0/0/0/0",
                     Busy, Din_Ready, Mult_Din, Mult_Coeff, Dout, Dout_Valid);
        else passed++;
        @(negedge Clk);
        Rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Dout_Valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) $display("[TB] FAIL abort_no_result: got %0d valid cycles want 0", seen); else passed++;
        send_sample(100);
        wait_result(d, lat);
        total++; if (lat >= 40 || d !== 24'sd0) $display("[TB] FAIL abort_coeff_cleared: got %0d want 0", d); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_impulse();
        test_neg_corner();
        test_saturation();
        test_backpressure();
        test_simul_write();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
